// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the M-extension multiply/divide unit: ALU op codes,
// request class encodings, FSM state type and latency constants.
package muldiv_unit_pkg;

  localparam int ALU_OP_WIDTH = 4;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_MUL    = 4'h0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_MULH   = 4'h1;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_MULHSU = 4'h2;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_MULHU  = 4'h3;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_DIV    = 4'h4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_DIVU   = 4'h5;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_REM    = 4'h6;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_REMU   = 4'h7;

  localparam logic [1:0] MULDIV_CLASS_MUL = 2'b01;
  localparam logic [1:0] MULDIV_CLASS_DIV = 2'b10;

  localparam int XLEN_DEFAULT = 32;
  localparam int MUL_LAT      = 2;
  localparam int DIV_LAT      = XLEN_DEFAULT + 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// Restoring shift-subtract divider datapath: one quotient bit per step on
// unsigned magnitudes. Sequencing and sign handling live in the parent FSM.
module div_iter #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o,
  output logic            last_o
);

  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN:0]    shifted;
  logic             fits;

  // Partial remainder with the next dividend bit shifted in, and the trial compare.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    fits    = (shifted >= {1'b0, dvs_q});
  end

  // Load operands, then retire one quotient bit per step; the difference
  // always fits in XLEN bits because it is below the divisor.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      quo_q <= dividend_i;
      rem_q <= '0;
      dvs_q <= divisor_i;
      cnt_q <= CNT_W'(XLEN - 1);
    end else if (step_i) begin
      rem_q <= fits ? (shifted[XLEN-1:0] - dvs_q) : shifted[XLEN-1:0];
      quo_q <= {quo_q[XLEN-2:0], fits};
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
  assign last_o      = (cnt_q == '0);

endmodule

// File: rtl/muldiv_unit.sv
// Sequential M-extension multiply/divide responder for the EX stage.
// Optional: define MULDIV_EARLY_OUT_EN to finish divide-by-zero and signed
// overflow requests directly from IDLE (same result, shorter latency).
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [1:0]              is_muldiv_i,
  input  logic [ALU_OP_WIDTH-1:0] alu_op_i,
  input  logic [XLEN-1:0]         op_a_i,
  input  logic [XLEN-1:0]         op_b_i,
  input  logic                    flush_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [XLEN-1:0]         result_o
);

  muldiv_state_t           state_q;
  logic [ALU_OP_WIDTH-1:0] op_q;
  logic [XLEN-1:0]         a_q, b_q;
  logic                    neg_quo_q, neg_rem_q, dzero_q, ovf_q;

  logic                    accept, is_div_req, sgn_in, dzero_in, ovf_in;
  logic [XLEN-1:0]         a_mag, b_mag;
  logic                    sa, sb;
  logic signed [XLEN:0]    ma, mb;
  logic signed [2*XLEN+1:0] prod;
  logic [XLEN-1:0]         mul_res, quo, rem, q_fix, r_fix, div_res;
  logic                    is_rem_q;
  logic                    div_last;
  logic                    unused_prod_top;

  // Result of divide-by-zero / signed overflow, shared by FIX and early-out.
  function automatic logic [XLEN-1:0] special_res(input logic is_rem,
                                                  input logic [XLEN-1:0] a,
                                                  input logic zero);
    if (is_rem) return zero ? a : '0;
    else        return zero ? '1 : a;
  endfunction

  // Request decode, operand magnitudes and special-case detection at accept.
  always_comb begin
    is_div_req = (is_muldiv_i == MULDIV_CLASS_DIV);
    accept     = (state_q == ST_IDLE) && start_i && !flush_i &&
                 ((is_muldiv_i == MULDIV_CLASS_MUL) || is_div_req);
    sgn_in     = (alu_op_i == ALU_DIV) || (alu_op_i == ALU_REM);
    a_mag      = (sgn_in && op_a_i[XLEN-1]) ? (~op_a_i + 1'b1) : op_a_i;
    b_mag      = (sgn_in && op_b_i[XLEN-1]) ? (~op_b_i + 1'b1) : op_b_i;
    dzero_in   = (op_b_i == '0);
    ovf_in     = sgn_in && (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_i == '1);
  end

  // Multiply on latched operands, extended one bit per operand by variant.
  always_comb begin
    sa      = (op_q != ALU_MULHU);
    sb      = (op_q == ALU_MUL) || (op_q == ALU_MULH);
    ma      = {sa & a_q[XLEN-1], a_q};
    mb      = {sb & b_q[XLEN-1], b_q};
    prod    = ma * mb;
    mul_res = (op_q == ALU_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  assign unused_prod_top = ^prod[2*XLEN+1:2*XLEN];

  // Sign correction of the magnitude result, then special-case override.
  always_comb begin
    is_rem_q = (op_q == ALU_REM) || (op_q == ALU_REMU);
    q_fix    = neg_quo_q ? (~quo + 1'b1) : quo;
    r_fix    = neg_rem_q ? (~rem + 1'b1) : rem;
    if (dzero_q || ovf_q) div_res = special_res(is_rem_q, a_q, dzero_q);
    else                  div_res = is_rem_q ? r_fix : q_fix;
  end

  div_iter #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_div_iter (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (accept && is_div_req),
    .step_i      (state_q == ST_DIV),
    .dividend_i  (a_mag),
    .divisor_i   (b_mag),
    .quotient_o  (quo),
    .remainder_o (rem),
    .last_o      (div_last)
  );

  // Control FSM; done_o is registered on leaving DONE, so a flush arriving
  // in DONE cannot retract it, while a flush elsewhere blocks result writes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      result_o  <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dzero_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (flush_i) begin
      state_q <= ST_IDLE;
      busy_o  <= 1'b0;
      done_o  <= (state_q == ST_DONE);
    end else begin
      done_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q      <= alu_op_i;
            a_q       <= op_a_i;
            b_q       <= op_b_i;
            neg_quo_q <= sgn_in && (op_a_i[XLEN-1] ^ op_b_i[XLEN-1]);
            neg_rem_q <= sgn_in && op_a_i[XLEN-1];
            dzero_q   <= dzero_in;
            ovf_q     <= ovf_in;
            busy_o    <= 1'b1;
            if (!is_div_req) begin
              state_q <= ST_MUL;
            end else begin
`ifdef MULDIV_EARLY_OUT_EN
              if (dzero_in || ovf_in) begin
                result_o <= special_res((alu_op_i == ALU_REM) || (alu_op_i == ALU_REMU),
                                        op_a_i, dzero_in);
                state_q  <= ST_DONE;
              end else begin
                state_q  <= ST_DIV;
              end
`else
              state_q <= ST_DIV;
`endif
            end
          end
        end
        ST_MUL: begin
          result_o <= mul_res;
          state_q  <= ST_DONE;
        end
        ST_DIV: begin
          if (div_last) state_q <= ST_FIX;
        end
        ST_FIX: begin
          result_o <= div_res;
          state_q  <= ST_DONE;
        end
        ST_DONE: begin
          done_o  <= 1'b1;
          busy_o  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_o  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
